// File: rtl/tap_win_if.sv
// Handshake bundle between tap_window_ctrl, its sample source, the tap line and the detector.
// With TAP_WIN_INDEX_EN defined the bundle also carries the 16-bit m_index window counter.
interface tap_win_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = 5
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;
  logic                  shift_en;
  logic [DATA_WIDTH-1:0] shift_din;
  logic                  clr;
  logic [CNT_W-1:0]      fill_cnt;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;
  logic                  busy;
`ifdef TAP_WIN_INDEX_EN
  logic [15:0]           m_index;

  modport master (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, shift_en, shift_din, clr, fill_cnt, m_valid, m_last, busy, m_index
  );
  modport slave (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, shift_en, shift_din, clr, fill_cnt, m_valid, m_last, busy, m_index
  );
`else
  modport master (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, shift_en, shift_din, clr, fill_cnt, m_valid, m_last, busy
  );
  modport slave (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, shift_en, shift_din, clr, fill_cnt, m_valid, m_last, busy
  );
`endif
endinterface

// File: rtl/tap_window_ctrl.sv
// Sequencer for the DETDES tap delay line: feeds samples, zero-pads frame tails, flags windows.
// Optional macro TAP_WIN_INDEX_EN adds the m_index window counter.
//
// state | meaning
// IDLE  | line empty, waiting for the first sample of a frame
// FILL  | accepting samples, line not yet full
// RUN   | line full, every accepted sample yields a window
// FLUSH | shifting REGDEPTH-1 zero pads, then waiting for the m_last handshake
// CLEAR | one-cycle clr pulse to the line, fill level back to zero
module tap_window_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int REGDEPTH   = 3,
  parameter int CNT_W      = 5
) (
  input  logic      clk,
  input  logic      rst,
  tap_win_if.master bus
);

  typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, CLEAR} state_t;

  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(REGDEPTH);
  localparam logic [CNT_W-1:0] PADS  = CNT_W'(REGDEPTH - 1);

  state_t           state_q;
  logic [CNT_W-1:0] fill_q;
  logic [CNT_W-1:0] fill_d;
  logic [CNT_W-1:0] pad_q;
  logic [CNT_W-1:0] pad_d;
  logic             m_valid_q;
  logic             m_last_q;

  logic win_free;
  logic s_ready;
  logic accept;
  logic pad_shift;
  logic shift;
  logic win_new;
  logic last_pad;
  logic hs;

  always_comb begin
    win_free = !m_valid_q || bus.m_ready;
    unique case (state_q)
      IDLE, FILL: s_ready = 1'b1;
      RUN:        s_ready = win_free;
      default:    s_ready = 1'b0;
    endcase
    accept    = bus.s_valid && s_ready;
    pad_shift = (state_q == FLUSH) && (pad_q != PADS) && win_free;
    shift     = accept || pad_shift;
    fill_d    = (fill_q == DEPTH) ? DEPTH : fill_q + 1'b1;
    pad_d     = pad_q + 1'b1;
    win_new   = shift && (fill_d == DEPTH);
    last_pad  = pad_shift && (pad_d == PADS);
    hs        = m_valid_q && bus.m_ready;
  end

  assign bus.s_ready   = s_ready;
  assign bus.shift_en  = shift;
  assign bus.shift_din = accept ? bus.s_data : {DATA_WIDTH{1'b0}};
  assign bus.clr       = (state_q == CLEAR);
  assign bus.busy      = (state_q != IDLE);
  assign bus.fill_cnt  = fill_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_last    = m_last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      fill_q    <= '0;
      pad_q     <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      if (shift) fill_q <= fill_d;
      if (pad_shift) pad_q <= pad_d;

      // a handshake and a fresh window in the same cycle keep m_valid high
      if (win_new)  m_valid_q <= 1'b1;
      else if (hs)  m_valid_q <= 1'b0;
      if (last_pad) m_last_q  <= 1'b1;
      else if (hs)  m_last_q  <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (accept) state_q <= bus.s_last ? FLUSH : FILL;
        end
        FILL: begin
          if (accept) begin
            if (bus.s_last)              state_q <= FLUSH;
            else if (fill_d == DEPTH)    state_q <= RUN;
          end
        end
        RUN: begin
          if (accept && bus.s_last) state_q <= FLUSH;
        end
        FLUSH: begin
          if (hs && m_last_q) state_q <= CLEAR;
        end
        CLEAR: begin
          state_q <= IDLE;
          fill_q  <= '0;
          pad_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef TAP_WIN_INDEX_EN
  logic [15:0] idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     idx_q <= '0;
    else if (hs) idx_q <= m_last_q ? 16'd0 : idx_q + 16'd1;
  end

  assign bus.m_index = idx_q;
`endif

endmodule

// File: tb/tb_tap_window_ctrl.sv
// Self-checking bench for tap_window_ctrl: models the tap line and predicts windows from padded frames.
module tb_tap_window_ctrl;
  localparam int DW = 32;
  localparam int R  = 3;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tap_win_if #(.DATA_WIDTH(DW), .CNT_W(CW)) bus ();

  tap_window_ctrl #(.DATA_WIDTH(DW), .REGDEPTH(R), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // the controlled line: taps[0] is newest
  logic [DW-1:0] taps [R];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < R; i++) taps[i] <= '0;
    end else if (bus.clr) begin
      for (int i = 0; i < R; i++) taps[i] <= '0;
    end else if (bus.shift_en) begin
      taps[0] <= bus.shift_din;
      for (int i = 1; i < R; i++) taps[i] <= taps[i-1];
    end
  end

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0]   frame    [$];
  logic [R*DW-1:0] exp_win  [$];
  bit              exp_last [$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [R*DW-1:0] line_win();
    logic [R*DW-1:0] w;
    for (int i = 0; i < R; i++) w[i*DW +: DW] = taps[i];
    return w;
  endfunction

  // window k of a frame is padded[k .. k+R-1], oldest in the deepest tap
  task automatic build_expected();
    logic [DW-1:0]   p [$];
    logic [R*DW-1:0] w;
    int              n;
    n = frame.size();
    exp_win.delete();
    exp_last.delete();
    p = frame;
    for (int j = 0; j < R - 1; j++) p.push_back('0);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < R; i++) w[i*DW +: DW] = p[k + R - 1 - i];
      exp_win.push_back(w);
      exp_last.push_back(k == n - 1);
    end
  endtask

  task automatic run_frame(input int vld_pct, input int rdy_pct, input int hold,
                           input int abort_at, input bit no_bubble, output bit aborted);
    int n, sent, budget, widx, hold_left, bubbles;
    bit seen;
    n = frame.size();
    build_expected();
    sent = 0; budget = 0; widx = 0; hold_left = hold; bubbles = 0; seen = 0; aborted = 0;
    while (exp_win.size() > 0 && budget < 3000) begin
      bus.s_valid = (sent < n) && ($urandom_range(99) < vld_pct);
      bus.s_data  = (sent < n) ? frame[sent] : DW'($urandom);
      bus.s_last  = (sent == n - 1);
      bus.m_ready = ($urandom_range(99) < rdy_pct);
      if (bus.m_valid && hold_left > 0) begin
        bus.m_ready = 1'b0;
        hold_left--;
      end
      @(negedge clk);
      if (bus.s_valid && bus.s_ready) sent++;
      if (seen && !bus.m_valid) bubbles++;
      if (bus.m_valid) begin
        seen = 1;
        chk("window", 128'(line_win()), 128'(exp_win[0]));
        chk("m_last", 128'(bus.m_last), 128'(exp_last[0]));
        chk("fill_full", 128'(bus.fill_cnt), 128'(R));
`ifdef TAP_WIN_INDEX_EN
        chk("m_index", 128'(bus.m_index), 128'(widx));
`endif
        if (!bus.m_ready) begin
          chk("bp_shift_en", 128'(bus.shift_en), 128'(0));
          chk("bp_s_ready", 128'(bus.s_ready), 128'(0));
        end
        if (widx == abort_at) begin
          aborted = 1;
          break;
        end
        if (bus.m_ready) begin
          void'(exp_win.pop_front());
          void'(exp_last.pop_front());
          widx++;
        end
      end
      budget++;
      @(posedge clk);
      #1;
    end
    if (!aborted) begin
      chk("windows_left", 128'(exp_win.size()), 128'(0));
      chk("samples_sent", 128'(sent), 128'(n));
      if (no_bubble) chk("bubbles", 128'(bubbles), 128'(0));
      bus.s_valid = 1'b0;
      bus.m_ready = 1'b0;
      chk("clr_pulse", 128'(bus.clr), 128'(1));
      chk("busy_in_clear", 128'(bus.busy), 128'(1));
      @(posedge clk);
      #1;
      chk("clr_done", 128'(bus.clr), 128'(0));
      chk("busy_idle", 128'(bus.busy), 128'(0));
      chk("fill_zero", 128'(bus.fill_cnt), 128'(0));
      chk("m_valid_idle", 128'(bus.m_valid), 128'(0));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m_valid"}, 128'(bus.m_valid), 128'(0));
    chk({tag, "_m_last"}, 128'(bus.m_last), 128'(0));
    chk({tag, "_fill"}, 128'(bus.fill_cnt), 128'(0));
    chk({tag, "_busy"}, 128'(bus.busy), 128'(0));
    chk({tag, "_clr"}, 128'(bus.clr), 128'(0));
    chk({tag, "_shift_en"}, 128'(bus.shift_en), 128'(0));
    chk({tag, "_shift_din"}, 128'(bus.shift_din), 128'(0));
  endtask

  initial begin
    bit ab;
    int len;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    frame = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    run_frame(100, 100, 0, -1, 1, ab);

    frame = '{32'hA5};
    run_frame(100, 100, 0, -1, 0, ab);

    frame = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    run_frame(100, 100, 4, -1, 0, ab);

    frame.delete();
    for (int i = 0; i < 8; i++) frame.push_back(32'h10 + 32'(i));
    run_frame(100, 100, 0, -1, 1, ab);

    frame.delete();
    for (int i = 0; i < 6; i++) frame.push_back(32'h20 + 32'(i));
    run_frame(100, 100, 0, 2, 0, ab);
    chk("abort_reached", 128'(ab), 128'(1));
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midframe_rst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    frame = '{32'd7, 32'd8, 32'd9};
    run_frame(100, 100, 0, -1, 0, ab);

    for (int f = 0; f < 12; f++) begin
      len = int'($urandom_range(1, 10));
      frame.delete();
      for (int i = 0; i < len; i++) frame.push_back(DW'($urandom));
      run_frame(int'($urandom_range(30, 100)), int'($urandom_range(30, 100)), 0, -1, 0, ab);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
